stick_main_core: RTL and testbench



---
 rtl/stick_pkg.sv | 17 +
 rtl/stick_main_core_if.sv | 14 +
 rtl/stick_sync_edge.sv | 30 +++
 rtl/stick_main_core.sv | 122 ++++++++++++
 tb/tb_stick_main_core.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stick_pkg.sv
// Shared types and constants for the stick frame controller.
package stick_pkg;

    // Frame FSM states, in transmit order.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        CNT_HI = 3'd2,
        CNT_LO = 3'd3,
        DATA   = 3'd4,
        CSUM   = 3'd5
    } state_t;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
    localparam int         IDX_W        = 12;

endpackage

// File: rtl/stick_main_core_if.sv
// Transmit byte link between the frame controller and the serial TX.
// Handshake: a byte moves on every clock edge where tx_vld and tx_rdy are
// both high. Once tx_vld is raised, tx_data is held and tx_vld stays high
// until that transfer happens; tx_rdy may change freely.
interface stick_main_core_if;
    import stick_pkg::*;

    logic [7:0] tx_data;
    logic       tx_vld;
    logic       tx_rdy;

    modport master (output tx_data, output tx_vld, input tx_rdy);
    modport slave  (input tx_data, input tx_vld, output tx_rdy);
endinterface

// File: rtl/stick_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus rising-edge detect.
module stick_sync_edge
    import stick_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Synchronizer chain; sync3 is the one-cycle delay used for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

endmodule

// File: rtl/stick_main_core.sv
// Frame-acquisition and transmit controller: each sync rising edge emits
// header, 16-bit frame number, FRAME_LEN samples and an XOR checksum.
module stick_main_core
    import stick_pkg::*;
#(
    parameter int         FRAME_LEN = 256,
    parameter int         TEST_MODE = 1,
    parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DEF
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  i_sync,
    input  logic [7:0]            i_adc_data,
    stick_main_core_if.master     tx,
    output logic                  o_busy,
    output logic [15:0]           o_frame_cnt,
    output logic                  o_sync_miss,
    output state_t                o_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t           state;
    logic             rise;
    logic             xfer;
    logic [7:0]       csum;
    logic [IDX_W-1:0] idx;

    // Ramp pattern in test mode, otherwise the live ADC sample.
    function automatic logic [7:0] sample_byte(input logic [IDX_W-1:0] i,
                                               input logic [7:0] adc);
        if (TEST_MODE != 0) return i[7:0];
        return adc;
    endfunction

    stick_sync_edge u_sync (
        .clk      (sys_clk),
        .rst      (rst_n),
        .async_in (i_sync),
        .rise     (rise)
    );

    assign xfer    = tx.tx_vld & tx.tx_rdy;
    assign o_busy  = (state != IDLE);
    assign o_state = state;

    // Frame FSM: next byte, checksum and counters advance only on a transfer.
    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= IDLE;
            tx.tx_vld   <= 1'b0;
            tx.tx_data  <= 8'h00;
            o_frame_cnt <= 16'h0000;
            o_sync_miss <= 1'b0;
            csum        <= 8'h00;
            idx         <= '0;
        end else begin
            // A sync edge outside IDLE is dropped, never queued.
            o_sync_miss <= rise && (state != IDLE);
            case (state)
                IDLE: begin
                    if (rise) begin
                        state      <= HDR;
                        tx.tx_vld  <= 1'b1;
                        tx.tx_data <= HDR_BYTE;
                        csum       <= 8'h00;
                        idx        <= '0;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        csum       <= csum ^ tx.tx_data;
                        tx.tx_data <= o_frame_cnt[15:8];
                        state      <= CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (xfer) begin
                        csum       <= csum ^ tx.tx_data;
                        tx.tx_data <= o_frame_cnt[7:0];
                        state      <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (xfer) begin
                        csum       <= csum ^ tx.tx_data;
                        idx        <= '0;
                        tx.tx_data <= sample_byte('0, i_adc_data);
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum <= csum ^ tx.tx_data;
                        if (idx == LAST_IDX) begin
                            // Checksum covers every byte including this last sample.
                            tx.tx_data <= csum ^ tx.tx_data;
                            state      <= CSUM;
                        end else begin
                            idx        <= idx + 1'b1;
                            tx.tx_data <= sample_byte(idx + 1'b1, i_adc_data);
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        tx.tx_vld   <= 1'b0;
                        tx.tx_data  <= 8'h00;
                        o_frame_cnt <= o_frame_cnt + 16'd1;
                        idx         <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    tx.tx_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stick_main_core.sv
// Bench for stick_main_core: directed sequence with randomized timing and
// back-pressure, checked against a frame-level reference model.
module tb_stick_main_core;
    import stick_pkg::*;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b1;
    logic        i_sync  = 1'b0;
    logic [7:0]  i_adc_data = 8'h00;
    logic        o_busy;
    logic [15:0] o_frame_cnt;
    logic        o_sync_miss;
    state_t      o_state;

    stick_main_core_if tif ();

    stick_main_core #(
        .FRAME_LEN (256),
        .TEST_MODE (1),
        .HDR_BYTE  (8'hA5)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .i_sync      (i_sync),
        .i_adc_data  (i_adc_data),
        .tx          (tif),
        .o_busy      (o_busy),
        .o_frame_cnt (o_frame_cnt),
        .o_sync_miss (o_sync_miss),
        .o_state     (o_state)
    );

    // Clock / cycle counter
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Ready driver: constant 1 or random per cycle; ADC data is noise.
    logic rdy_rand = 1'b0;
    initial begin
        tif.tx_rdy = 1'b1;
        forever begin
            @(posedge sys_clk);
            #1;
            tif.tx_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            i_adc_data = 8'($urandom);
        end
    end

    // Monitor: collects transferred bytes and per-frame statistics.
    logic [7:0] act_q[$];
    int         vld_len, vld_rises, vld_start, miss_cnt;
    int         stab_err = 0;
    logic       prev_vld = 1'b0, prev_rdy = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge sys_clk) begin
        if (rst_n) begin
            prev_vld = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            if (prev_vld && !prev_rdy && (!tif.tx_vld || tif.tx_data !== prev_data))
                stab_err++;
            if (tif.tx_vld && !prev_vld) begin
                vld_rises++;
                vld_start = cyc;
            end
            if (tif.tx_vld) vld_len++;
            if (tif.tx_vld && tif.tx_rdy) act_q.push_back(tif.tx_data);
            if (o_sync_miss) miss_cnt++;
            prev_vld  = tif.tx_vld;
            prev_rdy  = tif.tx_rdy;
            prev_data = tif.tx_data;
        end
    end

    // Scoreboard / reference model
    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic [15:0] model_cnt = 16'h0000;
    int         sync_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frame: header, frame number, ramp, XOR of everything before.
    task automatic build_exp();
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(model_cnt[15:8]);
        exp_q.push_back(model_cnt[7:0]);
        for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
        x = 8'h00;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
    endtask

    task automatic clear_stats();
        act_q.delete();
        vld_len   = 0;
        vld_rises = 0;
        vld_start = -1;
        miss_cnt  = 0;
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_nbytes"}, act_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < act_q.size())
                chk($sformatf("%s_byte%0d", tag, i), act_q[i], exp_q[i]);
        end
        model_cnt = model_cnt + 16'd1;
        chk({tag, "_frame_cnt"}, o_frame_cnt, model_cnt);
    endtask

    task automatic start_sync(input int hold);
        @(posedge sys_clk);
        #1;
        i_sync   = 1'b1;
        sync_cyc = cyc;
        repeat (hold) @(posedge sys_clk);
        #1;
        i_sync = 1'b0;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!o_busy && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        chk("frame_start_timeout", o_busy, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 5000) begin
            @(negedge sys_clk);
            n++;
        end
        chk("frame_end_timeout", o_busy, 1'b0);
    endtask

    // Full frame with ready held high: latency, length and content.
    task automatic run_frame(input string tag, input int hold);
        build_exp();
        clear_stats();
        start_sync(hold);
        wait_busy();
        wait_idle();
        chk({tag, "_vld_latency"}, vld_start, sync_cyc + 3);
        chk({tag, "_vld_len"}, vld_len, 260);
        chk({tag, "_vld_rises"}, vld_rises, 1);
        check_frame(tag);
    endtask

    initial begin
        // Reset then idle
        #23;
        chk("rst_vld", tif.tx_vld, 1'b0);
        chk("rst_data", tif.tx_data, 8'h00);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_frame_cnt", o_frame_cnt, 16'h0000);
        chk("rst_sync_miss", o_sync_miss, 1'b0);
        chk("rst_state", o_state, IDLE);
        @(posedge sys_clk);
        #1;
        rst_n = 1'b0;
        clear_stats();
        repeat (100) @(negedge sys_clk);
        chk("idle_no_vld", vld_rises, 0);
        chk("idle_busy", o_busy, 1'b0);

        // Single frame, ready always high
        repeat ($urandom_range(0, 20)) @(posedge sys_clk);
        run_frame("frame1", $urandom_range(2, 20));

        // Back-pressure: same content, data stable while stalled
        rdy_rand = 1'b1;
        build_exp();
        clear_stats();
        start_sync($urandom_range(2, 6));
        wait_busy();
        wait_idle();
        rdy_rand = 1'b0;
        chk("bp_vld_rises", vld_rises, 1);
        chk("bp_stable", stab_err, 0);
        check_frame("bp");

        // Sync during a frame: dropped, one miss pulse, no second frame
        build_exp();
        clear_stats();
        start_sync(2);
        wait_busy();
        repeat (100) @(negedge sys_clk);
        start_sync($urandom_range(2, 4));
        wait_idle();
        repeat (30) @(negedge sys_clk);
        chk("miss_pulses", miss_cnt, 1);
        chk("miss_vld_len", vld_len, 260);
        chk("miss_vld_rises", vld_rises, 1);
        chk("miss_busy_after", o_busy, 1'b0);
        check_frame("miss");

        // Back-to-back frames
        run_frame("b2b_a", 2);
        run_frame("b2b_b", 2);

        // Reset mid-frame at sample 50
        clear_stats();
        start_sync(2);
        wait_busy();
        begin
            int n = 0;
            while (act_q.size() < 53 && n < 2000) begin
                @(negedge sys_clk);
                n++;
            end
            chk("midrst_reach_timeout", 32'(act_q.size() >= 53), 32'd1);
        end
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("midrst_vld", tif.tx_vld, 1'b0);
        chk("midrst_frame_cnt", o_frame_cnt, 16'h0000);
        chk("midrst_busy", o_busy, 1'b0);
        chk("midrst_data", tif.tx_data, 8'h00);
        @(posedge sys_clk);
        #1;
        rst_n = 1'b0;
        model_cnt = 16'h0000;
        repeat (5) @(posedge sys_clk);
        run_frame("after_rst", $urandom_range(2, 8));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
